// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and word width.
package imem_loader_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      CHK    = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses for one
// cycle after the 4th byte of a word, with word holding the completed value.
import imem_loader_pkg::*;

module word_assembler (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              byte_en,
   input  logic [7:0]        byte_in,
   output logic              word_valid,
   output logic [WORD_W-1:0] word
);

   logic [1:0]        cnt_q, cnt_d;
   logic [23:0]       pack_q, pack_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              valid_q, valid_d;

   always_comb begin
      cnt_d   = cnt_q;
      pack_d  = pack_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (clr) begin
         cnt_d  = 2'd0;
         pack_d = 24'd0;
      end else if (byte_en) begin
         cnt_d = cnt_q + 2'd1;
         case (cnt_q)
            2'd0: pack_d[7:0]   = byte_in;
            2'd1: pack_d[15:8]  = byte_in;
            2'd2: pack_d[23:16] = byte_in;
            default: begin
               word_d  = {byte_in, pack_q};
               valid_d = 1'b1;
               pack_d  = 24'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= 2'd0;
         pack_q  <= 24'd0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pack_q  <= pack_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign word_valid = valid_q;
   assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader with length prefix; holds the core in reset
// until a load succeeds. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_LO | receiving length low byte
// LEN_HI | receiving length high byte, range check
// DATA   | receiving instruction bytes, writing words
// CHK    | receiving XOR checksum byte (checksum build only)
// DONE   | load succeeded, core released
// ERR    | load failed, core held in reset
import imem_loader_pkg::*;

module imem_loader #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_e FINAL_ST = CHK;
`else
   localparam state_e FINAL_ST = DONE;
`endif

   state_e          state_q, state_d;
   logic [15:0]     len_q, len_d;
   logic [ADDR_W:0] wl_q, wl_d;
   logic [15:0]     len_new;
   logic [15:0]     wl_next16;
   logic            xfer;
   logic            asm_clr;
   logic            asm_byte_en;
   logic            word_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
`endif

   assign rx_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == DATA)   || (state_q == CHK);
   assign xfer      = rx_valid && rx_ready;
   assign len_new   = {rx_data, len_q[7:0]};
   assign wl_next16 = 16'(wl_q) + 16'd1;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      wl_d        = wl_q;
      asm_clr     = 1'b0;
      asm_byte_en = xfer && (state_q == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d = sum_q;
      if (xfer && (state_q != CHK)) sum_d = sum_q ^ rx_data;
`endif
      if (word_valid) wl_d = wl_q + {{ADDR_W{1'b0}}, 1'b1};
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LEN_LO;
               len_d   = 16'd0;
               wl_d    = '0;
               asm_clr = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = 8'd0;
`endif
            end
         end
         LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = rx_data;
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (xfer) begin
               len_d = len_new;
               if (len_new == 16'd0)             state_d = FINAL_ST;
               else if (len_new > 16'(DEPTH))    state_d = ERR;
               else                              state_d = DATA;
            end
         end
         DATA: begin
            if (word_valid && (wl_next16 == len_q)) state_d = FINAL_ST;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK: begin
            if (xfer) state_d = (rx_data == sum_q) ? DONE : ERR;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= 16'd0;
         wl_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wl_q    <= wl_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr        (asm_clr),
      .byte_en    (asm_byte_en),
      .byte_in    (rx_data),
      .word_valid (word_valid),
      .word       (imem_wdata)
   );

   // The write address is the count of words already committed this load.
   assign imem_we      = word_valid;
   assign imem_addr    = wl_q[ADDR_W-1:0];
   assign words_loaded = wl_q;
   assign busy         = rx_ready;
   assign done         = (state_q == DONE);
   assign err          = (state_q == ERR);
   assign core_rst     = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader; covers the checksum build when
// IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [7:0]        rx_data = 8'd0;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_rst     (core_rst),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] w;
   } vec_t;

   vec_t        vecs [5];
   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  csum;
   logic [7:0]  tx_q [$];
   logic [31:0] exp_q [$];
   int          wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   logic [31:0] mem_model [DEPTH];

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr_q.push_back(int'(imem_addr));
         wr_data_q.push_back(imem_wdata);
         mem_model[imem_addr] = imem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b0;
      repeat (gap) tick();
      rx_data  = b;
      rx_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (rx_ready) break;
      end
      if (!rx_ready) chk("byte_accept_timeout", {31'd0, rx_ready}, 32'd1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      csum = csum ^ b;
   endtask

   task automatic send_chk(input logic [7:0] flip, input int gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(csum ^ flip, gap);
`endif
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 50; t++) begin
         if (!busy) break;
         tick();
      end
      chk("busy_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic load_vecs(input int n);
      tx_q.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         tx_q.push_back(vecs[i].b0);
         tx_q.push_back(vecs[i].b1);
         tx_q.push_back(vecs[i].b2);
         tx_q.push_back(vecs[i].b3);
         exp_q.push_back(vecs[i].w);
      end
   endtask

   task automatic run_load(input int gap_max, input logic [7:0] flip);
      int len;
      len = exp_q.size();
      wr_addr_q.delete();
      wr_data_q.delete();
      csum = 8'd0;
      pulse_start();
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("done_after_start", {31'd0, done}, 32'd0);
      chk("core_rst_loading", {31'd0, core_rst}, 32'd1);
      send_byte(len[7:0], $urandom_range(0, gap_max));
      send_byte(len[15:8], $urandom_range(0, gap_max));
      foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(0, gap_max));
      send_chk(flip, $urandom_range(0, gap_max));
      wait_idle();
   endtask

   task automatic check_writes();
      chk("write_count", wr_addr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
         chk("write_addr", wr_addr_q[i], i);
         chk("write_data", wr_data_q[i], exp_q[i]);
      end
   endtask

   task automatic check_done(input int nw);
      chk("done", {31'd0, done}, 32'd1);
      chk("err", {31'd0, err}, 32'd0);
      chk("core_rst_released", {31'd0, core_rst}, 32'd0);
      chk("words_loaded", 32'(words_loaded), nw);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h93, 8'h00, 8'h50, 8'h00, 32'h00500093};
      vecs[1] = '{8'h13, 8'h01, 8'ha0, 8'h00, 32'h00a00113};
      vecs[2] = '{8'hb3, 8'h81, 8'h20, 8'h00, 32'h002081b3};
      vecs[3] = '{8'hef, 8'hbe, 8'had, 8'hde, 32'hdeadbeef};
      vecs[4] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};

      // Reset, with start asserted in the same cycle as rst
      repeat (2) tick();
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_words_loaded", 32'(words_loaded), 32'd0);

      // Basic three-word load, no gaps
      load_vecs(3);
      run_load(0, 8'h00);
      check_writes();
      check_done(3);

      // Same stream under backpressure, then a five-word load
      run_load(5, 8'h00);
      check_writes();
      check_done(3);
      load_vecs(5);
      run_load(3, 8'h00);
      check_writes();
      check_done(5);

      // Zero length
      tx_q.delete();
      exp_q.delete();
      run_load(0, 8'h00);
      check_writes();
      check_done(0);

      // Oversize length 65
      wr_addr_q.delete();
      csum = 8'd0;
      pulse_start();
      send_byte(8'h41, 0);
      send_byte(8'h00, 0);
      repeat (3) tick();
      chk("ovr_err", {31'd0, err}, 32'd1);
      chk("ovr_done", {31'd0, done}, 32'd0);
      chk("ovr_core_rst", {31'd0, core_rst}, 32'd1);
      chk("ovr_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("ovr_busy", {31'd0, busy}, 32'd0);
      chk("ovr_writes", wr_addr_q.size(), 32'd0);

      // Maximum length: DEPTH words
      tx_q.delete();
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         logic [31:0] w;
         for (int j = 0; j < 4; j++) begin
            logic [7:0] b;
            b = 8'((4 * i + j) * 7 + 3);
            tx_q.push_back(b);
            w[8*j +: 8] = b;
         end
         exp_q.push_back(w);
      end
      run_load(0, 8'h00);
      check_writes();
      check_done(DEPTH);

      // Start while busy is ignored, then rst aborts
      load_vecs(3);
      wr_addr_q.delete();
      wr_data_q.delete();
      csum = 8'd0;
      mem_model[0] = 32'd0;
      pulse_start();
      send_byte(8'h03, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 5; i++) send_byte(tx_q[i], 0);
      pulse_start();
      tick();
      chk("busy_start_busy", {31'd0, busy}, 32'd1);
      chk("busy_start_ready", {31'd0, rx_ready}, 32'd1);
      chk("busy_start_wl", 32'(words_loaded), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_core_rst", {31'd0, core_rst}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_wl", 32'(words_loaded), 32'd0);
      chk("abort_writes", wr_addr_q.size(), 32'd1);
      chk("abort_word0", mem_model[0], 32'h00500093);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Corrupted checksum byte
      load_vecs(3);
      run_load(2, 8'h01);
      check_writes();
      chk("csum_bad_err", {31'd0, err}, 32'd1);
      chk("csum_bad_done", {31'd0, done}, 32'd0);
      chk("csum_bad_core_rst", {31'd0, core_rst}, 32'd1);
      run_load(0, 8'h00);
      check_done(3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
